// File: rtl/fetch_req_buffer.sv
// Fetch request buffer: issues word-aligned I-cache requests and queues in-order
// responses with their request address and branch prediction for the decoder.
package fetch_req_buffer_pkg;
   typedef struct packed {
      logic        valid;
      logic [63:0] predict_address;
      logic        predict_taken;
      logic [1:0]  cf_type;
   } branchpredict_sbe_t;
endpackage

module fetch_req_buffer
   import fetch_req_buffer_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               flush_i,
   input  logic [63:0]        fetch_address_i,
   input  logic               fetch_valid_i,
   input  branchpredict_sbe_t branch_predict_i,
   output logic               if_ready_o,
   output logic               fetch_req_o,
   output logic [63:0]        fetch_vaddr_o,
   input  logic               fetch_gnt_i,
   input  logic               fetch_rvalid_i,
   input  logic [31:0]        fetch_rdata_i,
   output logic               fetch_entry_valid_o,
   input  logic               fetch_entry_ready_i,
   output logic [63:0]        fetch_entry_address_o,
   output logic [31:0]        fetch_entry_rdata_o,
   output branchpredict_sbe_t fetch_entry_bp_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW:0]   DEPTH_W = (PW+1)'(DEPTH);
   localparam logic [PW-1:0] ONE     = PW'(1);

   logic [PW-1:0]      r_wr_ptr;
   logic [PW-1:0]      r_fill_ptr;
   logic [PW-1:0]      r_rd_ptr;
   logic [PW-1:0]      r_kill_cnt;
   logic [DEPTH-1:0]   r_filled;
   logic [63:0]        r_addr  [DEPTH];
   branchpredict_sbe_t r_bp    [DEPTH];
   logic [31:0]        r_rdata [DEPTH];

   logic [PW-1:0] w_occ;
   logic [PW-1:0] w_outstanding;
   logic [PW:0]   w_used;
   logic [AW-1:0] w_wr_idx;
   logic [AW-1:0] w_fill_idx;
   logic [AW-1:0] w_rd_idx;
   logic          w_push;
   logic          w_pop;
   logic          w_fill;
   logic          w_kill_rsp;

   assign w_occ         = r_wr_ptr - r_rd_ptr;
   assign w_outstanding = r_wr_ptr - r_fill_ptr;
   assign w_used        = {1'b0, w_occ} + {1'b0, r_kill_cnt};
   assign w_wr_idx      = r_wr_ptr[AW-1:0];
   assign w_fill_idx    = r_fill_ptr[AW-1:0];
   assign w_rd_idx      = r_rd_ptr[AW-1:0];

   // Killed in-flight requests still hold a slot's worth of credit until they return.
   assign fetch_req_o   = fetch_valid_i & ~flush_i & (w_used < DEPTH_W);
   assign if_ready_o    = fetch_req_o & fetch_gnt_i;
   assign fetch_vaddr_o = {fetch_address_i[63:2], 2'b00};

   assign fetch_entry_valid_o   = (w_occ != '0) & r_filled[w_rd_idx];
   assign fetch_entry_address_o = r_addr[w_rd_idx];
   assign fetch_entry_rdata_o   = r_rdata[w_rd_idx];
   assign fetch_entry_bp_o      = r_bp[w_rd_idx];

   assign w_push     = if_ready_o;
   assign w_pop      = fetch_entry_valid_o & fetch_entry_ready_i & ~flush_i;
   assign w_kill_rsp = fetch_rvalid_i & (r_kill_cnt != '0);
   assign w_fill     = fetch_rvalid_i & (r_kill_cnt == '0) & (w_outstanding != '0);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_wr_ptr   <= '0;
         r_fill_ptr <= '0;
         r_rd_ptr   <= '0;
         r_kill_cnt <= '0;
         r_filled   <= '0;
      end else if (flush_i) begin
         // Everything not yet returned becomes a kill; a response arriving now retires one.
         r_kill_cnt <= r_kill_cnt + w_outstanding - PW'(w_kill_rsp | w_fill);
         r_fill_ptr <= r_wr_ptr;
         r_rd_ptr   <= r_wr_ptr;
      end else begin
         if (w_push) begin
            r_wr_ptr           <= r_wr_ptr + ONE;
            r_filled[w_wr_idx] <= 1'b0;
         end
         if (w_fill) begin
            r_fill_ptr           <= r_fill_ptr + ONE;
            r_filled[w_fill_idx] <= 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + ONE;
         end
         if (w_kill_rsp) begin
            r_kill_cnt <= r_kill_cnt - ONE;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_addr[w_wr_idx] <= fetch_address_i;
         r_bp[w_wr_idx]   <= branch_predict_i;
      end
      if (w_fill & ~flush_i) begin
         r_rdata[w_fill_idx] <= fetch_rdata_i;
      end
   end

   a_rvalid_expected: assert property (@(posedge clk_i) disable iff (rst_i)
      fetch_rvalid_i |-> ((r_kill_cnt != '0) || (w_outstanding != '0)));

endmodule
